// File: rtl/mult_div_param.sv
// Sequential unsigned multiplier / restoring divider, one iteration per clock.
// Optional divide-error detection is enabled by defining MULT_DIV_ERR_EN.
module mult_div_param #(
    parameter int WIDTH = 16
) (
    input  logic               reloj,
    input  logic               reset,
    input  logic [2*WIDTH-1:0] ent_2n,
    input  logic [WIDTH-1:0]   ent_n,
    input  logic               go,
    input  logic               div_mult,
    output logic [2*WIDTH-1:0] sal,
    output logic               done,
    output logic               busy,
    output logic               err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   opb;
    logic               op_div;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     top;
    logic [WIDTH-1:0]   diff;
    logic               ge;

    // acc holds {partial product, multiplier} or {partial remainder, quotient}
    always_comb begin
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        top  = acc[2*WIDTH-1:WIDTH-1];
        ge   = top >= {1'b0, opb};
        diff = top[WIDTH-1:0] - opb;
        if (op_div) begin
            if (ge)
                acc_nxt = {diff, acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end
    end

`ifdef MULT_DIV_ERR_EN
    logic bad;
    assign bad = div_mult &&
                 (ent_n == '0 || ent_2n[2*WIDTH-1:WIDTH] >= ent_n);
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            opb    <= '0;
            op_div <= 1'b0;
            cnt    <= '0;
            sal    <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
`ifdef MULT_DIV_ERR_EN
            err    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        acc    <= div_mult ? ent_2n
                                           : {{WIDTH{1'b0}}, ent_2n[WIDTH-1:0]};
                        opb    <= ent_n;
                        op_div <= div_mult;
                        cnt    <= CW'(WIDTH);
`ifdef MULT_DIV_ERR_EN
                        err    <= bad;
                        if (bad) begin
                            state <= DONE;
                            done  <= 1'b1;
                            sal   <= '0;
                            cnt   <= '0;
                        end else begin
                            state <= BUSY;
                            busy  <= 1'b1;
                        end
`else
                        state  <= BUSY;
                        busy   <= 1'b1;
`endif
                    end
                end
                BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sal   <= acc_nxt;
                    end
                end
                DONE: begin
                    if (!go) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_param.sv
// Self-checking bench for mult_div_param at WIDTH=16.
// Expectations follow MULT_DIV_ERR_EN when the macro is defined.
module tb_mult_div_param;

    localparam int W = 16;
`ifdef MULT_DIV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          reloj = 1'b0;
    logic          reset = 1'b1;
    logic [2*W-1:0] ent_2n = '0;
    logic [W-1:0]  ent_n = '0;
    logic          go = 1'b0;
    logic          div_mult = 1'b0;
    logic [2*W-1:0] sal;
    logic          done;
    logic          busy;
    logic          err;

    mult_div_param #(.WIDTH(W)) dut (
        .reloj    (reloj),
        .reset    (reset),
        .ent_2n   (ent_2n),
        .ent_n    (ent_n),
        .go       (go),
        .div_mult (div_mult),
        .sal      (sal),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    always #5 reloj = ~reloj;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic        dm;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] sal;
        logic        err;
        logic        care;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    vec_t        vt[10];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_sal = '0;
    logic        last_known = 1'b1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b,
                                   input logic dm);
        exp_t e;
        e.err  = 1'b0;
        e.care = 1'b1;
        e.lat  = W;
        e.sal  = '0;
        if (!dm) begin
            e.sal = {16'h0, a[15:0]} * {16'h0, b};
        end else if (b == 16'h0 || a[31:16] >= b) begin
            if (ERR_EN) begin
                e.err = 1'b1;
                e.lat = 0;
            end else begin
                e.care = 1'b0;
            end
        end else begin
            e.sal = {16'(a % {16'h0, b}), 16'(a / {16'h0, b})};
        end
        return e;
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [15:0] b,
                         input logic dm, input logic hold, input exp_t e);
        int   n;
        int   bcnt;
        logic stable;
        exp_t r;
        @(negedge reloj);
        ent_2n   = a;
        ent_n    = b;
        div_mult = dm;
        go       = 1'b1;
        sb.push_back(e);
        @(posedge reloj);
        #1;
        ent_2n   = $urandom;
        ent_n    = 16'($urandom);
        div_mult = 1'($urandom);
        if (!hold) go = 1'b0;
        n      = 0;
        bcnt   = 0;
        stable = 1'b1;
        while (!done && n < 40) begin
            if (busy) bcnt++;
            if (last_known && sal !== last_sal) stable = 1'b0;
            @(posedge reloj);
            #1;
            n++;
        end
        r = sb.pop_front();
        check("latency", n, r.lat);
        check("busy_cycles", bcnt, r.lat);
        if (last_known) check("sal_stable_busy", {31'h0, stable}, 32'h1);
        if (r.care) check("sal", sal, r.sal);
        check("err", {31'h0, err}, {31'h0, r.err});
        last_sal   = r.sal;
        last_known = r.care;
        if (hold) begin
            repeat (3) @(posedge reloj);
            #1;
            check("done_held", {31'h0, done}, 32'h1);
            check("no_restart", {31'h0, busy}, 32'h0);
            if (r.care) check("sal_held", sal, r.sal);
        end
        go = 1'b0;
        @(posedge reloj);
        #1;
        check("done_drop", {31'h0, done}, 32'h0);
        check("idle_busy", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [15:0] b;
        logic        dm;
        exp_t        e;

        vt[0] = '{a: 32'd300,        b: 16'd200,  dm: 1'b0, exp: 32'h0000EA60};
        vt[1] = '{a: 32'd100000,     b: 16'd7,    dm: 1'b1, exp: 32'h000537CD};
        vt[2] = '{a: 32'hABCDFFFF,   b: 16'hFFFF, dm: 1'b0, exp: 32'hFFFE0001};
        vt[3] = '{a: 32'h00001234,   b: 16'h0,    dm: 1'b0, exp: 32'h0};
        vt[4] = '{a: 32'hFFFEFFFF,   b: 16'hFFFF, dm: 1'b1, exp: 32'hFFFEFFFF};
        vt[5] = '{a: 32'd100,        b: 16'd1,    dm: 1'b1, exp: 32'h00000064};
        vt[6] = '{a: 32'd7,          b: 16'd9,    dm: 1'b1, exp: 32'h00070000};
        vt[7] = '{a: 32'd1000,       b: 16'd0,    dm: 1'b1, exp: 32'h0};
        vt[8] = '{a: 32'h00050000,   b: 16'd5,    dm: 1'b1, exp: 32'h0};
        vt[9] = '{a: 32'h0000FFFF,   b: 16'd1,    dm: 1'b0, exp: 32'h0000FFFF};

        #1 reset = 1'b0;
        #2;
        check("rst_sal", sal, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        repeat (2) @(negedge reloj);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            e = model(vt[i].a, vt[i].b, vt[i].dm);
            if (e.care) e.sal = vt[i].exp;
            do_op(vt[i].a, vt[i].b, vt[i].dm, 1'b0, e);
        end

        // go held through BUSY and DONE
        do_op(32'd300, 16'd200, 1'b0, 1'b1, model(32'd300, 16'd200, 1'b0));

        // reset in the middle of an operation, between clock edges
        @(negedge reloj);
        ent_2n   = 32'd3;
        ent_n    = 16'd5;
        div_mult = 1'b0;
        go       = 1'b1;
        @(posedge reloj);
        #1 go = 1'b0;
        repeat (8) @(posedge reloj);
        #3 reset = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_sal", sal, 32'h0);
        check("abort_err", {31'h0, err}, 32'h0);
        @(negedge reloj);
        reset      = 1'b1;
        last_sal   = '0;
        last_known = 1'b1;
        do_op(32'd100000, 16'd7, 1'b1, 1'b0, model(32'd100000, 16'd7, 1'b1));

        for (int i = 0; i < 1000; i++) begin
            a  = $urandom;
            b  = 16'($urandom);
            dm = 1'($urandom);
            if (dm && ($urandom % 4 != 0)) begin
                if (b == 16'h0) b = 16'd1;
                a[31:16] = a[31:16] % b;
            end
            do_op(a, b, dm, 1'b0, model(a, b, dm));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
